// File: rtl/ex_div_pkg.sv
// Shared types and constants for the RV32M execute-stage divider.
package ex_div_pkg;

    // Controller states: waiting, iterating one quotient bit per cycle, result cycle
    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_CALC = 2'b01,
        DIV_END  = 2'b10
    } div_state_e;

    // funct3 encodings of the four RV32M divide instructions
    localparam logic [2:0] DIV_OP_DIV  = 3'b100;
    localparam logic [2:0] DIV_OP_DIVU = 3'b101;
    localparam logic [2:0] DIV_OP_REM  = 3'b110;
    localparam logic [2:0] DIV_OP_REMU = 3'b111;

    // DIV and REM treat operands as two's complement
    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    endfunction

    // REM and REMU return the remainder, the others the quotient
    function automatic logic op_is_rem(input logic [2:0] op);
        return !((op == DIV_OP_DIV) || (op == DIV_OP_DIVU));
    endfunction

endpackage

// File: rtl/ex_div.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Signed operations run on magnitudes and fix the sign in the result cycle.
// Divide-by-zero and signed overflow skip the iteration and finish in one cycle.
module ex_div
    import ex_div_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic [4:0]      reg_waddr_i,
    input  logic            cancel,
    output logic            busy,
    output logic            ready,
    output logic [XLEN-1:0] result,
    output logic [4:0]      reg_waddr_o,
    output logic            reg_we_o
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e      state, state_next;
    logic [2:0]      op_q;
    logic [4:0]      waddr_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] divisor_q;
    logic [CNT_W-1:0] cnt_q;
    logic            neg_quo_q;
    logic            neg_rem_q;
    logic [XLEN-1:0] result_q;

    logic            in_signed;
    logic            dividend_neg;
    logic            divisor_neg;
    logic [XLEN-1:0] dividend_abs;
    logic [XLEN-1:0] divisor_abs;
    logic            div_zero;
    logic            overflow;
    logic            accept;

    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   trial;
    logic            trial_ok;
    logic [XLEN-1:0] rem_iter;
    logic [XLEN-1:0] quo_iter;

    logic [XLEN-1:0] sel_val;
    logic            sel_neg;
    logic [XLEN-1:0] final_val;

    // Operand preparation: magnitudes, signs and the two short-circuit cases
    always_comb begin
        in_signed    = op_is_signed(op);
        dividend_neg = in_signed && dividend[XLEN-1];
        divisor_neg  = in_signed && divisor[XLEN-1];
        dividend_abs = dividend_neg ? (~dividend + 1'b1) : dividend;
        divisor_abs  = divisor_neg ? (~divisor + 1'b1) : divisor;
        div_zero     = (divisor == '0);
        overflow     = in_signed && (dividend == MIN_NEG) && (divisor == '1);
        accept       = start && !cancel;
    end

    // One restoring step: shift {rem, quo} left and try to subtract the divisor
    always_comb begin
        rem_shift = {rem_q, quo_q[XLEN-1]};
        trial     = rem_shift - {1'b0, divisor_q};
        trial_ok  = !trial[XLEN];
        rem_iter  = trial_ok ? trial[XLEN-1:0] : rem_shift[XLEN-1:0];
        quo_iter  = {quo_q[XLEN-2:0], trial_ok};
    end

    // Pick quotient or remainder and restore its sign
    always_comb begin
        sel_val   = op_is_rem(op_q) ? rem_q : quo_q;
        sel_neg   = op_is_rem(op_q) ? neg_rem_q : neg_quo_q;
        final_val = sel_neg ? (~sel_val + 1'b1) : sel_val;
    end

    // Next-state logic; cancel always wins and sends the controller home
    always_comb begin
        state_next = state;
        case (state)
            DIV_IDLE: begin
                if (accept) begin
                    state_next = (div_zero || overflow) ? DIV_END : DIV_CALC;
                end
            end
            DIV_CALC: begin
                if (cancel) begin
                    state_next = DIV_IDLE;
                end else if (cnt_q == CNT_W'(XLEN-1)) begin
                    state_next = DIV_END;
                end
            end
            DIV_END: begin
                state_next = DIV_IDLE;
            end
            default: begin
                state_next = DIV_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= DIV_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath: capture on start, iterate in CALC, remember the result in END
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q      <= '0;
            waddr_q   <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (accept) begin
                        op_q      <= op;
                        waddr_q   <= reg_waddr_i;
                        cnt_q     <= '0;
                        divisor_q <= divisor_abs;
                        if (div_zero) begin
                            // Quotient all ones; the remainder reproduces the dividend
                            quo_q     <= '1;
                            rem_q     <= dividend_abs;
                            neg_quo_q <= 1'b0;
                            neg_rem_q <= dividend_neg;
                        end else if (overflow) begin
                            quo_q     <= MIN_NEG;
                            rem_q     <= '0;
                            neg_quo_q <= 1'b0;
                            neg_rem_q <= 1'b0;
                        end else begin
                            quo_q     <= dividend_abs;
                            rem_q     <= '0;
                            neg_quo_q <= dividend_neg ^ divisor_neg;
                            neg_rem_q <= dividend_neg;
                        end
                    end
                end
                DIV_CALC: begin
                    if (!cancel) begin
                        rem_q <= rem_iter;
                        quo_q <= quo_iter;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DIV_END: begin
                    if (!cancel) begin
                        result_q <= final_val;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs: ready only in an uncancelled END cycle; result holds afterwards
    always_comb begin
        busy        = (state != DIV_IDLE);
        ready       = (state == DIV_END) && !cancel;
        reg_we_o    = ready;
        result      = ready ? final_val : result_q;
        reg_waddr_o = waddr_q;
    end

endmodule

// File: tb/tb_ex_div.sv
// Directed self-checking bench for ex_div: table of operations plus
// hand sequences for cancel, start-while-busy and asynchronous reset.
module tb_ex_div;
    import ex_div_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [4:0]  reg_waddr_i;
    logic        cancel;
    logic        busy;
    logic        ready;
    logic [31:0] result;
    logic [4:0]  reg_waddr_o;
    logic        reg_we_o;

    int checks;
    int errors;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  waddr;
        logic [31:0] exp_res;
        int          exp_lat;
    } vec_t;

    vec_t vecs[16];

    ex_div #(.XLEN(32), .CNT_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .dividend    (dividend),
        .divisor     (divisor),
        .reg_waddr_i (reg_waddr_i),
        .cancel      (cancel),
        .busy        (busy),
        .ready       (ready),
        .result      (result),
        .reg_waddr_o (reg_waddr_o),
        .reg_we_o    (reg_we_o)
    );

    // Free-running clock, 10 time-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one value and report a mismatch
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one operation (start high in cycle 0) and watch cycles 1..40.
    // exp_lat == 0 means no ready pulse is expected (cancelled operation).
    task automatic applyStimulus(input string name, input logic [2:0] o,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] wa, input logic [31:0] exp_res,
                                 input int exp_lat, input int restart_at,
                                 input int cancel_at);
        int          ready_cnt;
        int          busy_cnt;
        int          ready_cyc;
        int          we_err;
        logic [31:0] got_res;
        logic [4:0]  got_wa;
        ready_cnt = 0;
        busy_cnt  = 0;
        ready_cyc = -1;
        we_err    = 0;
        got_res   = '0;
        got_wa    = '0;
        @(negedge clk);
        op          = o;
        dividend    = a;
        divisor     = b;
        reg_waddr_i = wa;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        op          = DIV_OP_DIVU;
        dividend    = 32'hDEAD_BEEF;
        divisor     = 32'h0000_0001;
        reg_waddr_i = 5'd31;
        for (int k = 1; k <= 40; k++) begin
            if (busy) busy_cnt++;
            if (ready) begin
                ready_cnt++;
                ready_cyc = k;
                got_res   = result;
                got_wa    = reg_waddr_o;
            end
            if (reg_we_o !== ready) we_err++;
            if (cancel_at > 0 && k == cancel_at + 1)
                checkOutput({name, " busy after cancel"}, {31'b0, busy}, 32'd0);
            start  = 1'b0;
            cancel = 1'b0;
            if (k == restart_at) begin
                start    = 1'b1;
                op       = DIV_OP_DIVU;
                dividend = 32'd100;
                divisor  = 32'd7;
                reg_waddr_i = 5'd3;
            end
            if (k == cancel_at) cancel = 1'b1;
            @(negedge clk);
        end
        start  = 1'b0;
        cancel = 1'b0;
        checkOutput({name, " we==ready"}, we_err, 32'd0);
        if (exp_lat > 0) begin
            checkOutput({name, " ready pulses"}, ready_cnt, 32'd1);
            checkOutput({name, " ready cycle"}, ready_cyc, exp_lat);
            checkOutput({name, " result"}, got_res, exp_res);
            checkOutput({name, " waddr"}, {27'b0, got_wa}, {27'b0, wa});
            checkOutput({name, " busy cycles"}, busy_cnt, exp_lat);
            checkOutput({name, " result hold"}, result, exp_res);
        end else begin
            checkOutput({name, " ready pulses"}, ready_cnt, 32'd0);
            checkOutput({name, " busy cycles"}, busy_cnt, cancel_at);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b0;
        start       = 1'b0;
        op          = DIV_OP_DIVU;
        dividend    = '0;
        divisor     = '0;
        reg_waddr_i = '0;
        cancel      = 1'b0;

        vecs[0]  = '{"DIVU 20/3",      DIV_OP_DIVU, 32'd20,        32'd3,         5'd10, 32'd6,         33};
        vecs[1]  = '{"REMU 20/3",      DIV_OP_REMU, 32'd20,        32'd3,         5'd10, 32'd2,         33};
        vecs[2]  = '{"DIV -7/2",       DIV_OP_DIV,  32'hFFFFFFF9,  32'd2,         5'd1,  32'hFFFFFFFD,  33};
        vecs[3]  = '{"REM -7/2",       DIV_OP_REM,  32'hFFFFFFF9,  32'd2,         5'd2,  32'hFFFFFFFF,  33};
        vecs[4]  = '{"DIV 7/-2",       DIV_OP_DIV,  32'd7,         32'hFFFFFFFE,  5'd4,  32'hFFFFFFFD,  33};
        vecs[5]  = '{"REM 7/-2",       DIV_OP_REM,  32'd7,         32'hFFFFFFFE,  5'd5,  32'd1,         33};
        vecs[6]  = '{"DIVU x/0",       DIV_OP_DIVU, 32'h00001234,  32'd0,         5'd6,  32'hFFFFFFFF,  1};
        vecs[7]  = '{"REM x/0",        DIV_OP_REM,  32'h00001234,  32'd0,         5'd7,  32'h00001234,  1};
        vecs[8]  = '{"DIV ovf",        DIV_OP_DIV,  32'h80000000,  32'hFFFFFFFF,  5'd8,  32'h80000000,  1};
        vecs[9]  = '{"REM ovf",        DIV_OP_REM,  32'h80000000,  32'hFFFFFFFF,  5'd9,  32'd0,         1};
        vecs[10] = '{"DIV -100/-7",    DIV_OP_DIV,  32'hFFFFFF9C,  32'hFFFFFFF9,  5'd11, 32'd14,        33};
        vecs[11] = '{"REM -100/-7",    DIV_OP_REM,  32'hFFFFFF9C,  32'hFFFFFFF9,  5'd12, 32'hFFFFFFFE,  33};
        vecs[12] = '{"DIVU max/1",     DIV_OP_DIVU, 32'hFFFFFFFF,  32'd1,         5'd13, 32'hFFFFFFFF,  33};
        vecs[13] = '{"REMU max/10",    DIV_OP_REMU, 32'hFFFFFFFF,  32'd10,        5'd14, 32'd5,         33};
        vecs[14] = '{"DIVU big/2",     DIV_OP_DIVU, 32'hFFFFFFF9,  32'd2,         5'd15, 32'h7FFFFFFC,  33};
        vecs[15] = '{"REM -5/0",       DIV_OP_REM,  32'hFFFFFFFB,  32'd0,         5'd16, 32'hFFFFFFFB,  1};

        // Reset values while reset is held
        #12;
        checkOutput("reset busy",  {31'b0, busy},     32'd0);
        checkOutput("reset ready", {31'b0, ready},    32'd0);
        checkOutput("reset we",    {31'b0, reg_we_o}, 32'd0);
        checkOutput("reset result", result,           32'd0);
        checkOutput("reset waddr", {27'b0, reg_waddr_o}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                          vecs[i].waddr, vecs[i].exp_res, vecs[i].exp_lat, 0, 0);
        end

        // Cancel in cycle 10 of CALC, then a fresh operation
        applyStimulus("cancel DIVU", DIV_OP_DIVU, 32'd1000, 32'd3, 5'd20, 32'd0, 0, 0, 10);
        applyStimulus("DIVU 100/7", DIV_OP_DIVU, 32'd100, 32'd7, 5'd21, 32'd14, 33, 0, 0);

        // start re-pulsed mid-CALC with other operands is ignored
        applyStimulus("restart ignored", DIV_OP_DIVU, 32'd20, 32'd3, 5'd22, 32'd6, 33, 5, 0);

        // start together with cancel in IDLE is dropped
        @(negedge clk);
        op       = DIV_OP_DIVU;
        dividend = 32'd9;
        divisor  = 32'd3;
        start    = 1'b1;
        cancel   = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cancel = 1'b0;
        checkOutput("start+cancel busy", {31'b0, busy}, 32'd0);

        // Asynchronous reset in the middle of CALC
        @(negedge clk);
        op          = DIV_OP_DIVU;
        dividend    = 32'd77;
        divisor     = 32'd5;
        reg_waddr_i = 5'd9;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        checkOutput("pre-reset busy", {31'b0, busy}, 32'd1);
        #2 rst = 1'b0;
        #1;
        checkOutput("async rst busy",   {31'b0, busy},  32'd0);
        checkOutput("async rst ready",  {31'b0, ready}, 32'd0);
        checkOutput("async rst result", result,         32'd0);
        checkOutput("async rst waddr",  {27'b0, reg_waddr_o}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("post-reset busy", {31'b0, busy}, 32'd0);
        applyStimulus("recover REMU 77/5", DIV_OP_REMU, 32'd77, 32'd5, 5'd9, 32'd2, 33, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
